// File: rtl/iod_dly_ctrl_if.sv
// Request channel between the PHY training FSM and the IOD delay-line sequencer.
// The training side is the master; the sequencer is the slave.
interface iod_dly_ctrl_if #(
   parameter int unsigned TAP_W = 8
) ();
   logic             REQ_VALID;
   logic             REQ_READY;
   logic             REQ_LOAD;
   logic [TAP_W-1:0] REQ_TAP;
   logic             DONE;
   logic             ERR;
   logic             BUSY;

   modport master (
      output REQ_VALID, REQ_LOAD, REQ_TAP,
      input  REQ_READY, DONE, ERR, BUSY
   );

   modport slave (
      input  REQ_VALID, REQ_LOAD, REQ_TAP,
      output REQ_READY, DONE, ERR, BUSY
   );
endinterface

// File: rtl/iod_dly_ctrl.sv
// Sequencer for one IOD dynamic delay line: turns tap-set/load requests into
// spaced single-tap MOVE/LOAD pulses and tracks the current tap.
module iod_dly_ctrl #(
   parameter int unsigned TAP_W    = 8,
   parameter int unsigned LOAD_VAL = 1,
   parameter int unsigned MAX_TAP  = 255,
   parameter int unsigned SETTLE   = 4
) (
   input  logic             FAB_CLK,
   input  logic             RST_N,
   iod_dly_ctrl_if.slave    req,
   output logic [TAP_W-1:0] CUR_TAP,
   output logic             CAL,
   output logic             DELAY_LINE_MOVE,
   output logic             DELAY_LINE_DIRECTION,
   output logic             DELAY_LINE_LOAD,
   input  logic             DELAY_LINE_OUT_OF_RANGE
);

   localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_MOVE   = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   localparam logic [TAP_W-1:0] LOAD_TAP = TAP_W'(LOAD_VAL);
   localparam logic [TAP_W-1:0] MAX_T    = TAP_W'(MAX_TAP);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [TAP_W-1:0] r_target;
   logic             r_is_load;
   logic [TAP_W-1:0] r_prev_tap;
   logic [TAP_W-1:0] r_cur_tap;
   logic             r_dir;
   logic             r_cal;
   logic             r_ready;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic             r_move;
   logic             r_load;

   logic [2:0]       w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [TAP_W-1:0] w_target_nxt;
   logic             w_is_load_nxt;
   logic [TAP_W-1:0] w_prev_nxt;
   logic [TAP_W-1:0] w_cur_nxt;
   logic             w_dir_nxt;
   logic             w_cal_nxt;
   logic             w_ready_nxt;
   logic             w_busy_nxt;
   logic             w_err_nxt;
   logic             w_done_nxt;
   logic             w_move_nxt;
   logic             w_load_nxt;
   logic             w_accept;
   logic             w_up;
   logic [TAP_W-1:0] w_step;

   assign w_accept = req.REQ_VALID & r_ready;
   assign w_up     = req.REQ_TAP > r_cur_tap;
   // One tap toward the target in the direction latched for this request.
   assign w_step   = r_dir ? (r_cur_tap + TAP_W'(1)) : (r_cur_tap - TAP_W'(1));

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_target_nxt  = r_target;
      w_is_load_nxt = r_is_load;
      w_prev_nxt    = r_prev_tap;
      w_cur_nxt     = r_cur_tap;
      w_dir_nxt     = r_dir;
      w_cal_nxt     = r_cal;
      w_ready_nxt   = r_ready;
      w_busy_nxt    = r_busy;
      w_err_nxt     = r_err;

      case (r_state)
         S_IDLE: begin
            w_ready_nxt = 1'b1;
            if (w_accept) begin
               w_ready_nxt   = 1'b0;
               w_busy_nxt    = 1'b1;
               w_err_nxt     = 1'b0;
               w_target_nxt  = req.REQ_TAP;
               w_is_load_nxt = req.REQ_LOAD;
               if (req.REQ_LOAD) begin
                  w_state_nxt = S_LOAD;
                  w_prev_nxt  = r_cur_tap;
                  w_cur_nxt   = LOAD_TAP;
               end else if (!r_cal || (req.REQ_TAP > MAX_T)) begin
                  w_state_nxt = S_FINISH;
                  w_err_nxt   = 1'b1;
               end else if (req.REQ_TAP == r_cur_tap) begin
                  w_state_nxt = S_FINISH;
               end else begin
                  w_state_nxt = S_MOVE;
                  w_dir_nxt   = w_up;
                  w_prev_nxt  = r_cur_tap;
                  w_cur_nxt   = w_up ? (r_cur_tap + TAP_W'(1)) : (r_cur_tap - TAP_W'(1));
               end
            end
         end
         S_LOAD, S_MOVE: begin
            w_state_nxt = S_SETTLE;
            w_cnt_nxt   = CNT_LAST;
         end
         S_SETTLE: begin
            // The IOD range flag is only trusted on the last settle cycle.
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else if (DELAY_LINE_OUT_OF_RANGE) begin
               w_state_nxt = S_FINISH;
               w_err_nxt   = 1'b1;
               w_cur_nxt   = r_prev_tap;
               w_cal_nxt   = 1'b0;
            end else if (r_is_load) begin
               w_state_nxt = S_FINISH;
               w_cal_nxt   = 1'b1;
            end else if (r_cur_tap == r_target) begin
               w_state_nxt = S_FINISH;
            end else begin
               w_state_nxt = S_MOVE;
               w_prev_nxt  = r_cur_tap;
               w_cur_nxt   = w_step;
            end
         end
         S_FINISH: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_ready_nxt = 1'b1;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Pulses are registered so they line up with the state they belong to.
      w_done_nxt = (w_state_nxt == S_FINISH);
      w_move_nxt = (w_state_nxt == S_MOVE);
      w_load_nxt = (w_state_nxt == S_LOAD);
   end

   always_ff @(posedge FAB_CLK) begin
      if (!RST_N) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_target   <= '0;
         r_is_load  <= 1'b0;
         r_prev_tap <= LOAD_TAP;
         r_cur_tap  <= LOAD_TAP;
         r_dir      <= 1'b0;
         r_cal      <= 1'b0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_move     <= 1'b0;
         r_load     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_target   <= w_target_nxt;
         r_is_load  <= w_is_load_nxt;
         r_prev_tap <= w_prev_nxt;
         r_cur_tap  <= w_cur_nxt;
         r_dir      <= w_dir_nxt;
         r_cal      <= w_cal_nxt;
         r_ready    <= w_ready_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_err      <= w_err_nxt;
         r_move     <= w_move_nxt;
         r_load     <= w_load_nxt;
      end
   end

   assign req.REQ_READY         = r_ready;
   assign req.DONE              = r_done;
   assign req.ERR               = r_err;
   assign req.BUSY              = r_busy;
   assign CUR_TAP               = r_cur_tap;
   assign CAL                   = r_cal;
   assign DELAY_LINE_MOVE       = r_move;
   assign DELAY_LINE_DIRECTION  = r_dir;
   assign DELAY_LINE_LOAD       = r_load;

endmodule

// File: doc/iod_dly_ctrl.md
# iod_dly_ctrl

Sequencer for one IOD dynamic delay line (DELAY_LINE_MOVE / DIRECTION / LOAD / OUT_OF_RANGE) in the DDR4 PHY block.
- Accepts tap-set and load requests from training logic over a valid/ready handshake.
- Converts each request into correctly spaced single-tap move pulses.
- Tracks the current tap and reports completion or failure.
- Sits between the PHY training FSM and one lane's IOD instance, clocked by the fabric clock.

## Interface
Parameters:
- TAP_W, 8: tap index width; matches the IOD 8-bit delay value.
- LOAD_VAL, 1: tap value the IOD takes on DELAY_LINE_LOAD; equals the IOD TX_DELAY_VAL setting.
- MAX_TAP, 255: highest legal target tap.
- SETTLE, 4: idle cycles after each MOVE/LOAD pulse before the next action. Must be ≥1.

Ports:
- FAB_CLK  in  1  fabric clock; the only clock.
- RST_N  in  1  reset; synchronous, active-low.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  block can accept a request.
- REQ_LOAD  in  1  1 = reload the line to LOAD_VAL; 0 = move to REQ_TAP.
- REQ_TAP  in  TAP_W  target tap; ignored when REQ_LOAD=1.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  error status; valid while DONE=1.
- BUSY  out  1  request in progress.
- CUR_TAP  out  TAP_W  tracked current tap.
- CAL  out  1  a load has completed since reset.
- DELAY_LINE_MOVE  out  1  to IOD; one-cycle step pulse.
- DELAY_LINE_DIRECTION  out  1  to IOD; 1 = increment, 0 = decrement.
- DELAY_LINE_LOAD  out  1  to IOD; one-cycle reload pulse.
- DELAY_LINE_OUT_OF_RANGE  in  1  from IOD.

## Operation
- All outputs are registered.
- Reset values: REQ_READY=0 during reset and 1 afterwards. DONE, ERR, BUSY, CAL, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION and DELAY_LINE_LOAD = 0. CUR_TAP = LOAD_VAL.
- State machine: IDLE, LOAD, MOVE, SETTLE, FINISH.
- IDLE:
  - REQ_READY=1. A request is accepted on the edge where REQ_VALID & REQ_READY. Target and type are captured, BUSY goes to 1 and REQ_READY goes to 0.
  - REQ_LOAD=1 → LOAD.
  - REQ_LOAD=0 with CAL=0 → FINISH with ERR=1; no IOD activity.
  - REQ_TAP > MAX_TAP → FINISH with ERR=1; no IOD activity.
  - REQ_TAP == CUR_TAP → FINISH with ERR=0.
  - Otherwise → MOVE. DIRECTION is set to (REQ_TAP > CUR_TAP) and held for the whole request; it keeps its last value afterwards.
- LOAD: DELAY_LINE_LOAD=1 for one cycle. CUR_TAP ← LOAD_VAL, then → SETTLE.
- MOVE: DELAY_LINE_MOVE=1 for one cycle. CUR_TAP steps ±1 toward the target, then → SETTLE.
- SETTLE: counts SETTLE cycles. DELAY_LINE_OUT_OF_RANGE is sampled in the last cycle.
  - Sample set → FINISH with ERR=1. CUR_TAP reverts the last step. CAL ← 0.
  - Sample clear, after a load → FINISH, ERR=0, CAL ← 1.
  - Sample clear, after a move with CUR_TAP == target → FINISH, ERR=0.
  - Sample clear, target not yet reached → MOVE.
- FINISH: DONE=1 for one cycle, ERR valid with it, BUSY=0, → IDLE.
- ERR holds until the next accept. REQ_VALID is ignored while busy; there is no queueing.
- CUR_TAP arithmetic is unsigned TAP_W-bit and never wraps; the target bound prevents stepping past 0 or MAX_TAP.
- RST_N low in any state forces the reset values on the next edge. CAL returns to 0, so a load is required before any move.

## Timing
Accept edge = cycle 0.
- Zero-distance or rejected request: DONE in cycle 1.
- Load: DELAY_LINE_LOAD in cycle 1; DONE in cycle 2+SETTLE.
- Move of N taps: MOVE pulses in cycles 1, 1+(1+SETTLE), …; DONE in cycle 1+N·(1+SETTLE).
- REQ_READY returns to 1 in the cycle after DONE, so the earliest next accept is at the edge ending that cycle.
- DELAY_LINE_MOVE and DELAY_LINE_LOAD are never high in the same cycle.

## Test plan
- Reset, then move to 10 before any load → DONE at cycle 1 with ERR=1; no MOVE pulses; CUR_TAP=1.
- Load (SETTLE=4) → one LOAD pulse in cycle 1; DONE at cycle 6 with ERR=0; CAL=1; CUR_TAP=1.
- After load, move to 5 → 4 MOVE pulses with DIRECTION=1, spaced 5 cycles apart; DONE at cycle 21; CUR_TAP=5. Then move to 2 → 3 pulses with DIRECTION=0; CUR_TAP=2.
- Move to the current tap → DONE at cycle 1, ERR=0, no pulses. Target 256 with MAX_TAP=255 (TAP_W=9) → ERR=1, no pulses.
- OUT_OF_RANGE asserted during the settle after the 3rd of 6 steps → DONE with ERR=1; CUR_TAP = start+2; CAL=0; no further pulses.
- RST_N low mid-move → next cycle all outputs at reset values, CUR_TAP=LOAD_VAL; held REQ_VALID is accepted only after RST_N releases.
